// File: rtl/directory_msg_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : directory_msg_queue                                          |
// | Description : Outbound message FIFO for one directory-bank target queue.   |
// |               Captures alloc/opcode pulses with the shared bank outputs    |
// |               and presents the oldest message over valid/ready (FWFT).     |
// |               Optional macro DIR_MSG_Q_DEDUP_EN drops an INV that repeats  |
// |               the tail entry (same line, dest and opcode).                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module directory_msg_queue #(
  parameter int CL_SIZE      = 128,
  parameter int DEPTH        = 8,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alloc_in,
  input  logic [2:0]              operation_in,
  input  logic [31:0]             addr_in,
  input  logic [CL_SIZE-1:0]      data_in,
  input  logic [1:0]              src_in,
  input  logic [1:0]              dest_in,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic [2:0]              operation_out,
  output logic [31:0]             addr_out,
  output logic [CL_SIZE-1:0]      data_out,
  output logic [1:0]              src_out,
  output logic [1:0]              dest_out,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    almost_full,
  output logic                    empty,
  output logic                    overflow
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;
  // Entry layout, LSB first: dest, src, data, addr, operation
  localparam int c_ew       = CL_SIZE + 39;
  localparam int c_dest_lsb = 0;
  localparam int c_src_lsb  = 2;
  localparam int c_data_lsb = 4;
  localparam int c_addr_lsb = CL_SIZE + 4;
  localparam int c_op_lsb   = CL_SIZE + 36;
  localparam logic [c_cw-1:0] c_full_cnt  = c_cw'(DEPTH);
  localparam logic [c_cw-1:0] c_afull_cnt = c_cw'(DEPTH - AFULL_MARGIN);
  localparam logic [2:0]      c_op_noop   = 3'd0;

  logic [c_ew-1:0] r_mem [DEPTH];
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_cw-1:0] r_count;
  logic            r_overflow;

  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_req;
  logic            w_dup;
  logic            w_push;
  logic            w_drop;
  logic [c_ew-1:0] w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_full_cnt);
  assign w_pop   = !w_empty && ready_in;
  assign w_req   = alloc_in && (operation_in != c_op_noop);

`ifdef DIR_MSG_Q_DEDUP_EN
  localparam logic [2:0] c_op_inv = 3'd5;
  logic [c_aw-1:0] w_tail_idx;
  logic [2:0]      w_tail_op;
  logic [27:0]     w_tail_line;
  logic [1:0]      w_tail_dest;

  // The tail is the most recently written slot; it only counts while occupied.
  assign w_tail_idx  = r_wr_ptr - c_aw'(1);
  assign w_tail_op   = r_mem[w_tail_idx][c_op_lsb +: 3];
  assign w_tail_line = r_mem[w_tail_idx][c_addr_lsb + 4 +: 28];
  assign w_tail_dest = r_mem[w_tail_idx][c_dest_lsb +: 2];
  // A tail that is also the head being popped cannot absorb the duplicate.
  assign w_dup = (operation_in == c_op_inv) && !w_empty &&
                 (w_tail_op == c_op_inv) &&
                 (w_tail_line == addr_in[31:4]) &&
                 (w_tail_dest == dest_in) &&
                 !(w_pop && (r_count == c_cw'(1)));
`else
  assign w_dup = 1'b0;
`endif

  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign w_push = w_req && !w_dup && (!w_full || w_pop);
  assign w_drop = w_req && !w_dup && w_full && !w_pop;

  // Write the incoming message into the tail slot; storage is not reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {operation_in, addr_in, data_in, src_in, dest_in};
    end
  end

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
      r_count <= r_count + c_cw'(w_push) - c_cw'(w_pop);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  // First-word-fall-through head; fields read as zero while empty.
  always_comb begin
    operation_out = '0;
    addr_out      = '0;
    data_out      = '0;
    src_out       = '0;
    dest_out      = '0;
    if (!w_empty) begin
      operation_out = w_head[c_op_lsb +: 3];
      addr_out      = w_head[c_addr_lsb +: 32];
      data_out      = w_head[c_data_lsb +: CL_SIZE];
      src_out       = w_head[c_src_lsb +: 2];
      dest_out      = w_head[c_dest_lsb +: 2];
    end
  end

  assign valid_out   = !w_empty;
  assign empty       = w_empty;
  assign full        = w_full;
  assign almost_full = (r_count >= c_afull_cnt);
  assign count       = r_count;
  assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_directory_msg_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_directory_msg_queue                                       |
// | Description : Self-checking bench for directory_msg_queue: directed cases  |
// |               followed by random traffic against a queue-based model.      |
// |               Honours DIR_MSG_Q_DEDUP_EN when defined.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_directory_msg_queue;

  localparam int CL_SIZE      = 128;
  localparam int DEPTH        = 8;
  localparam int AFULL_MARGIN = 2;

  typedef struct {
    logic [2:0]         op;
    logic [31:0]        addr;
    logic [CL_SIZE-1:0] data;
    logic [1:0]         src;
    logic [1:0]         dest;
  } msg_t;

  logic                   clk;
  logic                   rst;
  logic                   alloc_in;
  logic [2:0]             operation_in;
  logic [31:0]            addr_in;
  logic [CL_SIZE-1:0]     data_in;
  logic [1:0]             src_in;
  logic [1:0]             dest_in;
  logic                   valid_out;
  logic                   ready_in;
  logic [2:0]             operation_out;
  logic [31:0]            addr_out;
  logic [CL_SIZE-1:0]     data_out;
  logic [1:0]             src_out;
  logic [1:0]             dest_out;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   almost_full;
  logic                   empty;
  logic                   overflow;

  msg_t mq[$];
  logic m_ovf;
  int   n_checks;
  int   n_pass;

  directory_msg_queue #(
    .CL_SIZE(CL_SIZE), .DEPTH(DEPTH), .AFULL_MARGIN(AFULL_MARGIN)
  ) dut (
    .clk(clk), .rst(rst), .alloc_in(alloc_in), .operation_in(operation_in),
    .addr_in(addr_in), .data_in(data_in), .src_in(src_in), .dest_in(dest_in),
    .valid_out(valid_out), .ready_in(ready_in), .operation_out(operation_out),
    .addr_out(addr_out), .data_out(data_out), .src_out(src_out),
    .dest_out(dest_out), .count(count), .full(full), .almost_full(almost_full),
    .empty(empty), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [CL_SIZE-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Compare every DUT output against the model's current queue contents.
  task automatic check_outputs();
    int n = mq.size();
    chk("valid_out", valid_out, n != 0);
    chk("count", count, n);
    chk("empty", empty, n == 0);
    chk("full", full, n == DEPTH);
    chk("almost_full", almost_full, n >= DEPTH - AFULL_MARGIN);
    chk("overflow", overflow, m_ovf);
    if (n == 0) begin
      chk("head_zero", {operation_out, addr_out, data_out, src_out, dest_out}, '0);
    end else begin
      chk("op_out", operation_out, mq[0].op);
      chk("addr_out", addr_out, mq[0].addr);
      chk("data_out", data_out, mq[0].data);
      chk("src_out", src_out, mq[0].src);
      chk("dest_out", dest_out, mq[0].dest);
    end
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model.
  task automatic step(input logic a, input logic [2:0] op, input logic [31:0] ad,
                      input logic [1:0] ds, input logic r);
    msg_t m;
    msg_t last;
    logic pop, req, dup, acc;
    m.op = op; m.addr = ad; m.data = rnd_line(); m.src = 2'($urandom_range(1, 3)); m.dest = ds;
    alloc_in = a; operation_in = op; addr_in = ad; data_in = m.data;
    src_in = m.src; dest_in = ds; ready_in = r;
    #1;
    check_outputs();
    pop = (mq.size() > 0) && r;
    req = a && (op != 3'd0);
    dup = 1'b0;
`ifdef DIR_MSG_Q_DEDUP_EN
    if (req && op == 3'd5 && mq.size() > 0 && !(pop && mq.size() == 1)) begin
      last = mq[$];
      if (last.op == 3'd5 && last.addr[31:4] == ad[31:4] && last.dest == ds) dup = 1'b1;
    end
`else
    last = m;
`endif
    acc = req && !dup && (mq.size() < DEPTH || pop);
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back(m);
    if (req && !dup && !acc) m_ovf = 1'b1;
    @(negedge clk);
  endtask

  // Raise reset between clock edges and check that it acts without a clock.
  task automatic async_reset();
    alloc_in = 1'b0; ready_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_afull", almost_full, 1'b0);
    mq.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int rdy_pct;
    n_checks = 0; n_pass = 0; m_ovf = 1'b0;
    rst = 1'b1; alloc_in = 1'b0; operation_in = '0; addr_in = '0; data_in = '0;
    src_in = '0; dest_in = '0; ready_in = 1'b0;
    #2;
    chk("por_valid", valid_out, 1'b0);
    chk("por_count", count, 0);
    chk("por_empty", empty, 1'b1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Single push, pop, then idle.
    step(1'b1, 3'd3, 32'h0000_1230, 2'd2, 1'b0);
    step(1'b0, 3'd0, 32'h0, 2'd0, 1'b1);
    step(1'b0, 3'd0, 32'h0, 2'd0, 1'b0);

    // Fill to full, simultaneous push/pop at full, then a dropped alloc.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 3'(2 + i % 6), 32'h100 * i, 2'd1, 1'b0);
    step(1'b1, 3'd6, 32'h0000_ABC0, 2'd3, 1'b1);
    step(1'b1, 3'd4, 32'h0000_DEAD, 2'd1, 1'b0);
    step(1'b1, 3'd0, 32'h0000_BEEF, 2'd1, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 3'd0, 32'h0, 2'd0, 1'b1);

    // NOOP alloc is ignored.
    step(1'b1, 3'd0, 32'h0000_5550, 2'd2, 1'b0);
    step(1'b0, 3'd0, 32'h0, 2'd0, 1'b0);

    // Asynchronous reset with five entries queued.
    for (int i = 0; i < 5; i++) step(1'b1, 3'd3, 32'h2000 + 32'(i), 2'd2, 1'b0);
    async_reset();
    step(1'b1, 3'd7, 32'h0000_7770, 2'd3, 1'b0);
    step(1'b0, 3'd0, 32'h0, 2'd0, 1'b1);

    // Back-to-back INV to the same line, then the same pair with a pop between.
    step(1'b1, 3'd5, 32'h0000_4000, 2'd1, 1'b0);
    step(1'b1, 3'd5, 32'h0000_400C, 2'd1, 1'b0);
    step(1'b0, 3'd0, 32'h0, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 32'h0, 2'd0, 1'b1);
    step(1'b1, 3'd5, 32'h0000_4000, 2'd1, 1'b0);
    step(1'b1, 3'd5, 32'h0000_400C, 2'd1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 32'h0, 2'd0, 1'b1);

    // Random traffic with phases of varying consumer back-pressure.
    async_reset();
    rdy_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      logic [2:0] op;
      if (c % 200 == 0) rdy_pct = (c / 200) % 3 == 0 ? 15 : ((c / 200) % 3 == 1 ? 50 : 90);
      op = ($urandom_range(0, 99) < 40) ? 3'd5 : 3'($urandom_range(0, 7));
      step($urandom_range(0, 99) < 70, op, 32'h4000 + 32'($urandom_range(0, 40)),
           2'($urandom_range(1, 2)), $urandom_range(0, 99) < rdy_pct);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
